// File: rtl/obi_ram_arbiter_pkg.sv
// Shared types and constants for the RAM-port arbiter: the OBI request and
// response channels, the requester count and outstanding-transaction depth,
// and the requester index map.
package obi_ram_arbiter_pkg;

    // OBI address/data phase driven by a requester
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    // OBI grant and response phase returned to a requester
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Requester slots on the shared RAM port; these match the crossbar master indices
    localparam int CORE_INSTR_IDX = 0;
    localparam int CORE_DATA_IDX  = 1;
    localparam int DEBUG_IDX      = 2;
    localparam int DMA_IDX        = 3;
    localparam int EXT_MASTER_IDX = 4;

    localparam int RAM_ARB_NREQ            = 5;
    localparam int RAM_ARB_MAX_OUTSTANDING = 2;

    // Round-robin successor of idx in the range 0..n-1
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/obi_ram_arbiter_id_fifo.sv
// In-order ID FIFO: holds the requester index of every granted transaction
// until its response returns. The head entry is valid combinationally.
module obi_id_fifo #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage
    // NOTE: the storage array has no reset; the count guarantees no entry is read before it is written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_ram_arbiter.sv
// Round-robin arbiter sharing the single RAM OBI slave port among NREQ
// requesters. The address phase is held stable while the RAM stalls, each
// accepted transaction's requester index is queued, and responses are steered
// back in order without the RAM knowing who asked.
module obi_ram_arbiter
    import obi_ram_arbiter_pkg::*;
#(
    parameter int NREQ            = RAM_ARB_NREQ,
    parameter int MAX_OUTSTANDING = RAM_ARB_MAX_OUTSTANDING
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  master_req_i  [NREQ],
    output obi_resp_t master_resp_o [NREQ],
    output obi_req_t  slave_req_o,
    input  obi_resp_t slave_resp_i,
    output logic      busy_o,
    output logic      err_o
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             lock_q;
    logic             err_q;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             active;
    logic             fwd_req;
    logic             handshake;
    logic             pop;
    logic             stray;

    logic [IDX_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] count_q;

    // Winner selection: the locked requester, else the first requester at or after the pointer
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        if (lock_q) begin
            winner = lock_idx_q;
            found  = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
                if (!found && master_req_i[cand].req) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    // A request leaves only while fewer than MAX_OUTSTANDING responses are pending;
    // a pop in the same cycle does not free a slot, so gnt never depends on rvalid.
    assign active    = !rst_i && found && master_req_i[winner].req;
    assign fwd_req   = active && !fifo_full;
    assign handshake = fwd_req && slave_resp_i.gnt;
    assign pop       = !rst_i && slave_resp_i.rvalid && !fifo_empty;
    assign stray     = !rst_i && slave_resp_i.rvalid && fifo_empty;

    // Forward the winner's address phase to the RAM; idle bus when nobody is asking
    always_comb begin
        slave_req_o = '0;
        if (active) begin
            slave_req_o     = master_req_i[winner];
            slave_req_o.req = fwd_req;
        end
    end

    // Grant goes to the winner only; rvalid goes to the FIFO head; rdata is broadcast
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            master_resp_o[i].gnt    = 1'b0;
            master_resp_o[i].rvalid = 1'b0;
            master_resp_o[i].rdata  = rst_i ? '0 : slave_resp_i.rdata;
            if (handshake && (winner == IDX_W'(i))) begin
                master_resp_o[i].gnt = 1'b1;
            end
            if (pop && (fifo_head == IDX_W'(i))) begin
                master_resp_o[i].rvalid = 1'b1;
            end
        end
    end

    // Round-robin pointer, address-phase lock and sticky stray-response flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr_q <= IDX_W'(rr_next(int'(winner), NREQ));
                lock_q   <= 1'b0;
            end else if (fwd_req) begin
                lock_q     <= 1'b1;
                lock_idx_q <= winner;
            end
            if (stray) begin
                err_q <= 1'b1;
            end
        end
    end

    obi_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_q)
    );

    assign busy_o = lock_q || (count_q != '0);
    assign err_o  = err_q;

endmodule

// File: tb/tb_obi_ram_arbiter.sv
// Self-checking bench for obi_ram_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_obi_ram_arbiter;
    import obi_ram_arbiter_pkg::*;

    localparam int NREQ = 5;
    localparam int MAXO = 2;

    logic      clk;
    logic      rst_i;
    obi_req_t  mreq  [NREQ];
    obi_resp_t mresp [NREQ];
    obi_req_t  sreq;
    obi_resp_t sresp;
    logic      busy;
    logic      err;

    obi_ram_arbiter #(
        .NREQ            (NREQ),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .master_req_i  (mreq),
        .master_resp_o (mresp),
        .slave_req_o   (sreq),
        .slave_resp_i  (sresp),
        .busy_o        (busy),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pointer, locked requester (-1 = none), queue of pending requester ids
    int       m_ptr;
    int       m_lock;
    int       m_q[$];
    bit       m_err;
    obi_req_t pl [NREQ];

    // Values observed in the most recent cycle, for directed checks
    obi_req_t        last_sreq;
    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] last_rv;
    logic            last_busy;
    logic            last_err;
    logic [31:0]     last_rdata;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] gnt_vec();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = mresp[i].gnt;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] rv_vec();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = mresp[i].rvalid;
        return v;
    endfunction

    task automatic regen(input int i);
        pl[i].req   = 1'b0;
        pl[i].we    = 1'($urandom);
        pl[i].be    = 4'($urandom);
        pl[i].addr  = $urandom;
        pl[i].wdata = $urandom;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_lock = -1;
        m_q.delete();
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int i = 0; i < NREQ; i++) mreq[i] = '0;
        sresp = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // One bus cycle: drive at edge+1, compare at edge+4, advance the model at the edge
    task automatic cycle(input logic [NREQ-1:0] mask, input logic g, input logic rv,
                         input logic [31:0] rd);
        int              w;
        int              c;
        int              pre_n;
        bit              fwd;
        obi_req_t        exp_sreq;
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_rv;
        if (m_lock >= 0) mask[m_lock] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            mreq[i]     = pl[i];
            mreq[i].req = mask[i];
        end
        sresp.gnt    = g;
        sresp.rvalid = rv;
        sresp.rdata  = rd;
        #3;
        pre_n = m_q.size();
        w = -1;
        if (m_lock >= 0) w = m_lock;
        else begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (w < 0 && mask[c]) w = c;
            end
        end
        exp_sreq = '0;
        fwd = 1'b0;
        if (w >= 0 && mask[w]) begin
            fwd          = (pre_n < MAXO);
            exp_sreq     = pl[w];
            exp_sreq.req = fwd;
        end
        exp_gnt = '0;
        if (fwd && g) exp_gnt[w] = 1'b1;
        exp_rv = '0;
        if (rv && pre_n > 0) exp_rv[m_q[0]] = 1'b1;

        last_sreq  = sreq;
        last_gnt   = gnt_vec();
        last_rv    = rv_vec();
        last_busy  = busy;
        last_err   = err;
        last_rdata = mresp[0].rdata;

        check("slave_req", sreq, exp_sreq);
        check("gnt_vec", last_gnt, exp_gnt);
        check("rvalid_vec", last_rv, exp_rv);
        for (int i = 0; i < NREQ; i++) check($sformatf("rdata[%0d]", i), mresp[i].rdata, rd);
        check("busy", busy, (m_lock >= 0) || (pre_n > 0));
        check("err", err, m_err);

        if (rv) begin
            if (pre_n > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (fwd && g) begin
            m_q.push_back(w);
            m_ptr  = (w + 1) % NREQ;
            m_lock = -1;
            regen(w);
        end else if (fwd) begin
            m_lock = w;
        end
        @(posedge clk);
        #1;
    endtask

    int       order [6];
    obi_req_t p1;

    initial begin
        rst_i = 1'b1;
        sresp = '0;
        for (int i = 0; i < NREQ; i++) begin
            mreq[i] = '0;
            regen(i);
        end

        // Reset state with an idle bus
        do_reset();
        cycle(5'b00000, 1'b0, 1'b0, 32'h0);
        check("rst_sreq", last_sreq, '0);
        check("rst_busy", last_busy, 1'b0);
        check("rst_err", last_err, 1'b0);

        // Single requester: master 2 granted, response routed back to it only
        cycle(5'b00100, 1'b1, 1'b0, 32'h0);
        check("single_gnt", last_gnt, 5'b00100);
        cycle(5'b00000, 1'b0, 1'b1, 32'hDEADBEEF);
        check("single_rv", last_rv, 5'b00100);
        check("single_rdata", last_rdata, 32'hDEADBEEF);
        cycle(5'b11111, 1'b1, 1'b0, 32'h0);
        check("single_ptr3", last_gnt, 5'b01000);

        // Fairness: everyone requests, RAM always grants and answers
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(5'b11111, 1'b1, k > 0, $urandom);
            order[k] = -1;
            for (int i = 0; i < NREQ; i++) if (last_gnt[i]) order[k] = i;
        end
        for (int k = 0; k < 6; k++) check($sformatf("fair_order[%0d]", k), order[k], k % NREQ);

        // Lock: master 1 stalled for 3 cycles keeps its address phase, master 3 waits
        do_reset();
        p1     = pl[1];
        p1.req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(5'b01010, 1'b0, 1'b0, 32'h0);
            check("lock_hold", last_sreq, p1);
            check("lock_nognt", last_gnt, 5'b00000);
        end
        cycle(5'b01010, 1'b1, 1'b0, 32'h0);
        check("lock_release_gnt", last_gnt, 5'b00010);
        cycle(5'b01010, 1'b1, 1'b0, 32'h0);
        check("lock_next_m3", last_gnt, 5'b01000);

        // Full: two outstanding block the third, even with a same-cycle pop
        do_reset();
        cycle(5'b00011, 1'b1, 1'b0, 32'h0);
        check("full_g0", last_gnt, 5'b00001);
        cycle(5'b00011, 1'b1, 1'b0, 32'h0);
        check("full_g1", last_gnt, 5'b00010);
        cycle(5'b00100, 1'b1, 1'b0, 32'h0);
        check("full_blocked_req", last_sreq.req, 1'b0);
        check("full_busy", last_busy, 1'b1);
        cycle(5'b00100, 1'b1, 1'b1, 32'h1234);
        check("full_pop_rv", last_rv, 5'b00001);
        check("full_pop_nognt", last_gnt, 5'b00000);
        cycle(5'b00100, 1'b1, 1'b0, 32'h0);
        check("full_proceeds", last_gnt, 5'b00100);

        // In-order responses for out-of-order masters, then a stray rvalid
        do_reset();
        cycle(5'b10000, 1'b1, 1'b0, 32'h0);
        check("ooo_g4", last_gnt, 5'b10000);
        cycle(5'b00001, 1'b1, 1'b0, 32'h0);
        check("ooo_g0", last_gnt, 5'b00001);
        cycle(5'b00000, 1'b0, 1'b1, 32'h11);
        check("ooo_rv4", last_rv, 5'b10000);
        check("ooo_rd11", last_rdata, 32'h11);
        cycle(5'b00000, 1'b0, 1'b1, 32'h22);
        check("ooo_rv0", last_rv, 5'b00001);
        cycle(5'b00000, 1'b0, 1'b1, 32'h33);
        check("stray_norv", last_rv, 5'b00000);
        cycle(5'b00000, 1'b0, 1'b0, 32'h0);
        check("stray_err", last_err, 1'b1);

        // Reset with one outstanding and a lock held
        do_reset();
        cycle(5'b00001, 1'b1, 1'b0, 32'h0);
        cycle(5'b00110, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < NREQ; i++) begin
            mreq[i]     = pl[i];
            mreq[i].req = (i == 1 || i == 2);
        end
        sresp.gnt    = 1'b1;
        sresp.rvalid = 1'b1;
        sresp.rdata  = 32'hCAFE0000;
        #2;
        check("pre_rst_busy", busy, 1'b1);
        rst_i = 1'b1;
        #1;
        check("arst_sreq", sreq, '0);
        check("arst_gnt", gnt_vec(), 5'b00000);
        check("arst_rv", rv_vec(), 5'b00000);
        check("arst_busy", busy, 1'b0);
        check("arst_err", err, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        cycle(5'b00000, 1'b0, 1'b1, 32'h55);
        check("post_rst_stray_norv", last_rv, 5'b00000);
        cycle(5'b11111, 1'b1, 1'b0, 32'h0);
        check("post_rst_ptr0", last_gnt, 5'b00001);
        check("post_rst_err", last_err, 1'b1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(NREQ'($urandom), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
